// File: rtl/idli_stack_m.sv
// idli_stack_m: parametrised LIFO stack with occupancy count, full/empty
// flags, sticky overflow/underflow errors, synchronous clear and a peek port.
// The top and peek reads are combinational from the state registers, so the
// read latency is zero. The storage array has no reset. Every output is masked
// by the live count, so stale entries are never visible.

module idli_stack_m #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1),
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             i_stack_gck,
  input  logic             i_stack_rst,
  input  logic             i_stack_clr,
  input  logic             i_stack_push,
  input  logic             i_stack_pop,
  input  logic [WIDTH-1:0] i_stack_data,
  output logic [WIDTH-1:0] o_stack_data,
  input  logic [IDX_W-1:0] i_stack_peek_idx,
  output logic [WIDTH-1:0] o_stack_peek_data,
  output logic             o_stack_peek_vld,
  output logic [CNT_W-1:0] o_stack_count,
  output logic             o_stack_empty,
  output logic             o_stack_full,
  output logic             o_stack_ovf,
  output logic             o_stack_udf
);

  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             wr_en_d;
  logic [IDX_W-1:0] wr_idx_d;

  logic [IDX_W-1:0] top_idx_s;
  logic [CNT_W-1:0] peek_ext_s;
  logic [IDX_W-1:0] peek_pos_s;
  logic             peek_vld_s;

  // Next-state decode: reset/clear dominate, then the push/pop operation table.
  always_comb begin
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    wr_en_d  = 1'b0;
    wr_idx_d = IDX_W'(count_q);
    if (i_stack_rst || i_stack_clr) begin
      count_d = CNT_ZERO;
      ovf_d   = 1'b0;
      udf_d   = 1'b0;
    end else begin
      case ({i_stack_push, i_stack_pop})
        2'b10: begin
          if (count_q != CNT_DEPTH) begin
            wr_en_d  = 1'b1;
            wr_idx_d = IDX_W'(count_q);
            count_d  = count_q + CNT_ONE;
          end else begin
            ovf_d = 1'b1;
          end
        end
        2'b01: begin
          if (count_q != CNT_ZERO) begin
            count_d = count_q - CNT_ONE;
          end else begin
            udf_d = 1'b1;
          end
        end
        2'b11: begin
          // Replace the top in place. This is legal when full, and it is a
          // pop-on-empty when there is no top to replace.
          if (count_q != CNT_ZERO) begin
            wr_en_d  = 1'b1;
            wr_idx_d = IDX_W'(count_q - CNT_ONE);
          end else begin
            udf_d = 1'b1;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
    end
  end

  // Control state registers with synchronous active-high reset.
  always_ff @(posedge i_stack_gck) begin
    if (i_stack_rst) begin
      count_q <= CNT_ZERO;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage array write port. It has no reset, because the count masks its contents.
  always_ff @(posedge i_stack_gck) begin
    if (wr_en_d) begin
      mem_q[wr_idx_d] <= i_stack_data;
    end
  end

  // Zero-latency top/peek reads and status flags derived from the state.
  always_comb begin
    top_idx_s  = IDX_W'(count_q - CNT_ONE);
    peek_ext_s = CNT_W'(i_stack_peek_idx);
    peek_vld_s = (peek_ext_s < count_q);
    peek_pos_s = IDX_W'(count_q - CNT_ONE - peek_ext_s);

    o_stack_count = count_q;
    o_stack_empty = (count_q == CNT_ZERO);
    o_stack_full  = (count_q == CNT_DEPTH);
    o_stack_ovf   = ovf_q;
    o_stack_udf   = udf_q;

    if (count_q != CNT_ZERO) begin
      o_stack_data = mem_q[top_idx_s];
    end else begin
      o_stack_data = {WIDTH{1'b0}};
    end

    o_stack_peek_vld = peek_vld_s;
    if (peek_vld_s) begin
      o_stack_peek_data = mem_q[peek_pos_s];
    end else begin
      o_stack_peek_data = {WIDTH{1'b0}};
    end
  end

endmodule

// File: tb/tb_idli_stack_m.sv
// Testbench for idli_stack_m. It drives a 4x4 instance and a 16-bit x5
// instance. A queue model predicts every output after each clock. The
// predictions go to a scoreboard when the stimulus is driven, and each one
// is compared with the DUT after the edge.

module tb_idli_stack_m;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: WIDTH=4, DEPTH=4
  logic        rst0, clr0, push0, pop0;
  logic [3:0]  din0, dout0, pkd0;
  logic [1:0]  pki0;
  logic        pkv0, emp0, full0, ovf0, udf0;
  logic [2:0]  cnt0;

  // Instance 1: WIDTH=16, DEPTH=5
  logic        rst1, clr1, push1, pop1;
  logic [15:0] din1, dout1, pkd1;
  logic [2:0]  pki1;
  logic        pkv1, emp1, full1, ovf1, udf1;
  logic [2:0]  cnt1;

  idli_stack_m #(.WIDTH(4), .DEPTH(4)) u_dut0 (
    .i_stack_gck(clk), .i_stack_rst(rst0), .i_stack_clr(clr0),
    .i_stack_push(push0), .i_stack_pop(pop0), .i_stack_data(din0),
    .o_stack_data(dout0), .i_stack_peek_idx(pki0), .o_stack_peek_data(pkd0),
    .o_stack_peek_vld(pkv0), .o_stack_count(cnt0), .o_stack_empty(emp0),
    .o_stack_full(full0), .o_stack_ovf(ovf0), .o_stack_udf(udf0)
  );

  idli_stack_m #(.WIDTH(16), .DEPTH(5)) u_dut1 (
    .i_stack_gck(clk), .i_stack_rst(rst1), .i_stack_clr(clr1),
    .i_stack_push(push1), .i_stack_pop(pop1), .i_stack_data(din1),
    .o_stack_data(dout1), .i_stack_peek_idx(pki1), .o_stack_peek_data(pkd1),
    .o_stack_peek_vld(pkv1), .o_stack_count(cnt1), .o_stack_empty(emp1),
    .o_stack_full(full1), .o_stack_ovf(ovf1), .o_stack_udf(udf1)
  );

  typedef struct {
    int          sel;
    int          cnt;
    logic [15:0] top;
    logic [15:0] pk;
    bit          pkv;
    bit          emp;
    bit          full;
    bit          ovf;
    bit          udf;
  } exp_t;

  exp_t        sb_q[$];
  logic [15:0] mdl0[$];
  logic [15:0] mdl1[$];
  bit          m_ovf[2];
  bit          m_udf[2];
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Compare the oldest scoreboard entry against the selected DUT.
  task automatic compare_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      check_eq("sb_underrun", 32'd1, 32'd0);
      return;
    end
    e = sb_q.pop_front();
    if (e.sel == 0) begin
      check_eq("cnt0",  {29'd0, cnt0},  e.cnt);
      check_eq("top0",  {28'd0, dout0}, {16'd0, e.top});
      check_eq("pk0",   {28'd0, pkd0},  {16'd0, e.pk});
      check_eq("pkv0",  {31'd0, pkv0},  {31'd0, e.pkv});
      check_eq("emp0",  {31'd0, emp0},  {31'd0, e.emp});
      check_eq("full0", {31'd0, full0}, {31'd0, e.full});
      check_eq("ovf0",  {31'd0, ovf0},  {31'd0, e.ovf});
      check_eq("udf0",  {31'd0, udf0},  {31'd0, e.udf});
    end else begin
      check_eq("cnt1",  {29'd0, cnt1},  e.cnt);
      check_eq("top1",  {16'd0, dout1}, {16'd0, e.top});
      check_eq("pk1",   {16'd0, pkd1},  {16'd0, e.pk});
      check_eq("pkv1",  {31'd0, pkv1},  {31'd0, e.pkv});
      check_eq("emp1",  {31'd0, emp1},  {31'd0, e.emp});
      check_eq("full1", {31'd0, full1}, {31'd0, e.full});
      check_eq("ovf1",  {31'd0, ovf1},  {31'd0, e.ovf});
      check_eq("udf1",  {31'd0, udf1},  {31'd0, e.udf});
    end
  endtask

  // Drive one cycle on instance sel, update the model, queue the prediction, and compare.
  task automatic step(input int sel, input bit rst, input bit clr, input bit push,
                      input bit pop, input logic [15:0] data, input int idx);
    logic [15:0] m[$];
    int          depth;
    logic [15:0] d;
    exp_t        e;
    @(negedge clk);
    rst0 = 1'b0; clr0 = 1'b0; push0 = 1'b0; pop0 = 1'b0;
    rst1 = 1'b0; clr1 = 1'b0; push1 = 1'b0; pop1 = 1'b0;
    if (sel == 0) begin
      rst0 = rst; clr0 = clr; push0 = push; pop0 = pop;
      din0 = data[3:0]; pki0 = 2'(idx);
      m = mdl0; depth = 4; d = {12'd0, data[3:0]};
    end else begin
      rst1 = rst; clr1 = clr; push1 = push; pop1 = pop;
      din1 = data; pki1 = 3'(idx);
      m = mdl1; depth = 5; d = data;
    end
    if (rst || clr) begin
      m.delete();
      m_ovf[sel] = 1'b0;
      m_udf[sel] = 1'b0;
    end else if (push && !pop) begin
      if (m.size() < depth) m.push_back(d);
      else m_ovf[sel] = 1'b1;
    end else if (pop && !push) begin
      if (m.size() > 0) void'(m.pop_back());
      else m_udf[sel] = 1'b1;
    end else if (push && pop) begin
      if (m.size() > 0) m[m.size()-1] = d;
      else m_udf[sel] = 1'b1;
    end
    e.sel  = sel;
    e.cnt  = m.size();
    e.top  = (m.size() > 0) ? m[m.size()-1] : 16'd0;
    e.pkv  = (idx < m.size());
    e.pk   = e.pkv ? m[m.size()-1-idx] : 16'd0;
    e.emp  = (m.size() == 0);
    e.full = (m.size() == depth);
    e.ovf  = m_ovf[sel];
    e.udf  = m_udf[sel];
    sb_q.push_back(e);
    if (sel == 0) mdl0 = m;
    else mdl1 = m;
    @(posedge clk);
    #1;
    compare_out();
  endtask

  initial begin
    rst0 = 1'b1; clr0 = 1'b0; push0 = 1'b0; pop0 = 1'b0; din0 = 4'd0; pki0 = 2'd0;
    rst1 = 1'b1; clr1 = 1'b0; push1 = 1'b0; pop1 = 1'b0; din1 = 16'd0; pki1 = 3'd0;

    // Reset both instances.
    step(0, 1, 0, 0, 0, 16'd0, 0);
    step(1, 1, 0, 0, 0, 16'd0, 0);
    check_eq("rst_empty", {31'd0, emp0}, 32'd1);
    check_eq("rst_top",   {28'd0, dout0}, 32'd0);

    // 1: push 3,5,9, then peek at depth 2 and depth 3.
    step(0, 0, 0, 1, 0, 16'd3, 2);
    step(0, 0, 0, 1, 0, 16'd5, 2);
    step(0, 0, 0, 1, 0, 16'd9, 2);
    check_eq("t1_cnt",  {29'd0, cnt0}, 32'd3);
    check_eq("t1_top",  {28'd0, dout0}, 32'd9);
    check_eq("t1_pk2",  {28'd0, pkd0}, 32'd3);
    step(0, 0, 0, 0, 0, 16'd0, 3);
    check_eq("t1_pkv3", {31'd0, pkv0}, 32'd0);

    // 2: fill with 1..4, push 7 to overflow, then drain.
    step(0, 0, 1, 0, 0, 16'd0, 0);
    for (int i = 1; i <= 4; i++) step(0, 0, 0, 1, 0, 16'(i), 1);
    step(0, 0, 0, 1, 0, 16'd7, 0);
    check_eq("t2_full", {31'd0, full0}, 32'd1);
    check_eq("t2_ovf",  {31'd0, ovf0}, 32'd1);
    check_eq("t2_top",  {28'd0, dout0}, 32'd4);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 16'd0, 0);
    check_eq("t2_empty", {31'd0, emp0}, 32'd1);

    // 3: pop on empty, then push+pop on empty, then clear.
    step(0, 0, 1, 0, 0, 16'd0, 0);
    step(0, 0, 0, 0, 1, 16'd0, 0);
    step(0, 0, 0, 1, 1, 16'd8, 0);
    check_eq("t3_udf", {31'd0, udf0}, 32'd1);
    check_eq("t3_cnt", {29'd0, cnt0}, 32'd0);
    step(0, 0, 1, 0, 0, 16'd0, 0);
    check_eq("t3_clr_udf", {31'd0, udf0}, 32'd0);

    // 4: replace the top while partly full, then replace it again when full.
    step(0, 0, 0, 1, 0, 16'd1, 1);
    step(0, 0, 0, 1, 0, 16'd2, 1);
    step(0, 0, 0, 1, 1, 16'hA, 1);
    check_eq("t4_top", {28'd0, dout0}, 32'hA);
    check_eq("t4_pk1", {28'd0, pkd0}, 32'd1);
    step(0, 0, 0, 1, 0, 16'd3, 0);
    step(0, 0, 0, 1, 0, 16'd4, 0);
    step(0, 0, 0, 1, 1, 16'hB, 3);
    check_eq("t4_ovf", {31'd0, ovf0}, 32'd0);

    // 5: clear together with push on a full stack, then push 6.
    step(0, 0, 1, 1, 0, 16'hC, 0);
    check_eq("t5_cnt", {29'd0, cnt0}, 32'd0);
    step(0, 0, 0, 1, 0, 16'd6, 0);
    check_eq("t5_top", {28'd0, dout0}, 32'd6);

    // Random operations against the model.
    for (int i = 0; i < 80; i++)
      step(0, ($urandom_range(0, 39) == 0), ($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           16'($urandom_range(0, 15)), $urandom_range(0, 3));

    // 6: DEPTH=5, WIDTH=16. Push past full, peek beyond DEPTH, then pulse reset mid-pop.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0, 16'h1000 + 16'(i * 16'h111), 4);
    step(1, 0, 0, 1, 0, 16'hFFFF, 4);
    check_eq("t6_cnt5", {29'd0, cnt1}, 32'd5);
    check_eq("t6_top",  {16'd0, dout1}, 32'h1444);
    for (int i = 5; i < 8; i++) step(1, 0, 0, 0, 0, 16'd0, i);
    step(1, 0, 0, 0, 1, 16'd0, 1);
    step(1, 0, 0, 0, 1, 16'd0, 1);
    step(1, 1, 0, 0, 1, 16'd0, 0);
    check_eq("t6_rst_cnt", {29'd0, cnt1}, 32'd0);
    check_eq("t6_rst_top", {16'd0, dout1}, 32'd0);
    check_eq("t6_rst_ovf", {31'd0, ovf1}, 32'd0);
    step(1, 0, 0, 0, 1, 16'd0, 0);
    step(1, 0, 0, 0, 1, 16'd0, 0);

    check_eq("sb_drained", sb_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog, so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
